// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: samples RXDATASB while RXCKSB is high and assembles PKT_WIDTH-bit packets, LSB first.
// Optional feature macro: SB_RX_PARITY_CHECK_EN (even-parity check on each completed packet).
module sb_rx_deserializer #(
    parameter int PKT_WIDTH = 64,
    parameter int GAP_MIN   = 32
) (
    input  logic                 pll_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 RXCKSB,
    input  logic                 RXDATASB,
    output logic [PKT_WIDTH-1:0] data_out,
    output logic                 de_ser_done,
    output logic                 trunc_err,
    output logic                 gap_err,
    output logic                 parity_err
);
    localparam int CW = $clog2(PKT_WIDTH);
    localparam int GW = $clog2(GAP_MIN + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(PKT_WIDTH - 1);
    localparam logic [GW-1:0] GAP_SAT  = GW'(GAP_MIN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [PKT_WIDTH-1:0]   shift_q, shift_d;
    logic [PKT_WIDTH-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   trunc_q, trunc_d;
    logic                   gap_err_q, gap_err_d;

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= GAP_SAT;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            trunc_q   <= 1'b0;
            gap_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            trunc_q   <= trunc_d;
            gap_err_q <= gap_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        trunc_d   = 1'b0;
        gap_err_d = 1'b0;

        // Idle-cycle counter runs regardless of enable; the start of a packet clears it below.
        if (!RXCKSB && (gap_cnt_q != GAP_SAT)) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        if (!enable) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    state_d = ST_IDLE;
                    if (RXCKSB) begin
                        shift_d[0] = RXDATASB;
                        bit_cnt_d  = CW'(1);
                        gap_cnt_d  = '0;
                        gap_err_d  = (gap_cnt_q < GAP_SAT);
                        state_d    = ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    if (RXCKSB) begin
                        shift_d[bit_cnt_q] = RXDATASB;
                        bit_cnt_d          = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            data_d  = shift_d;
                            done_d  = 1'b1;
                            state_d = ST_GAP;
                        end
                    end else begin
                        trunc_d   = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_GAP;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign de_ser_done = done_q;
    assign trunc_err   = trunc_q;
    assign gap_err     = gap_err_q;

`ifdef SB_RX_PARITY_CHECK_EN
    logic parity_q;

    // Even parity over the completed word, registered alongside the done strobe.
    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= done_d & (^data_d);
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Bench for sb_rx_deserializer: directed packets with a per-cycle behavioural model plus literal spot checks.
module tb_sb_rx_deserializer;
  localparam int W       = 64;
  localparam int GAP_MIN = 32;

  logic         pll_clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         RXCKSB;
  logic         RXDATASB;
  logic [W-1:0] data_out;
  logic         de_ser_done;
  logic         trunc_err;
  logic         gap_err;
  logic         parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_on  = 1'b0;

  sb_rx_deserializer #(.PKT_WIDTH(W), .GAP_MIN(GAP_MIN)) dut (
    .pll_clk    (pll_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .RXCKSB     (RXCKSB),
    .RXDATASB   (RXDATASB),
    .data_out   (data_out),
    .de_ser_done(de_ser_done),
    .trunc_err  (trunc_err),
    .gap_err    (gap_err),
    .parity_err (parity_err)
  );

  // clock / reset
  always #5 pll_clk = ~pll_clk;

  // behavioural model: a packet is "open" after an accepted first bit and
  // closes on the 64th bit, on a line drop, or when the receiver is disabled
  logic         m_open;
  int           m_cnt;
  int           m_idle;
  logic [W-1:0] m_word;
  logic [W-1:0] e_data;
  logic         e_done, e_trunc, e_gap, e_par;

  always @(posedge pll_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_open  <= 1'b0;
      m_cnt   <= 0;
      m_idle  <= GAP_MIN;
      m_word  <= '0;
      e_data  <= '0;
      e_done  <= 1'b0;
      e_trunc <= 1'b0;
      e_gap   <= 1'b0;
      e_par   <= 1'b0;
    end else begin
      e_done  <= 1'b0;
      e_trunc <= 1'b0;
      e_gap   <= 1'b0;
      e_par   <= 1'b0;
      if (!RXCKSB) m_idle <= (m_idle + 1 > GAP_MIN) ? GAP_MIN : m_idle + 1;
      if (!enable) begin
        m_open <= 1'b0;
        m_cnt  <= 0;
      end else if (!m_open) begin
        if (RXCKSB) begin
          e_gap     <= (m_idle < GAP_MIN);
          m_idle    <= 0;
          m_word[0] <= RXDATASB;
          m_cnt     <= 1;
          m_open    <= 1'b1;
        end
      end else if (RXCKSB) begin
        if (m_cnt == W - 1) begin
          e_data <= {RXDATASB, m_word[W-2:0]};
          e_done <= 1'b1;
`ifdef SB_RX_PARITY_CHECK_EN
          e_par  <= ^{RXDATASB, m_word[W-2:0]};
`endif
          m_open <= 1'b0;
          m_cnt  <= 0;
        end else begin
          m_word[m_cnt] <= RXDATASB;
          m_cnt         <= m_cnt + 1;
        end
      end else begin
        e_trunc <= 1'b1;
        m_open  <= 1'b0;
        m_cnt   <= 0;
      end
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge pll_clk) begin
    if (cmp_on) begin
      chk("cyc_data_out", data_out, e_data);
      chk("cyc_done", W'(de_ser_done), W'(e_done));
      chk("cyc_trunc", W'(trunc_err), W'(e_trunc));
      chk("cyc_gap", W'(gap_err), W'(e_gap));
      chk("cyc_parity", W'(parity_err), W'(e_par));
    end
  end

  // pulse counters for literal per-test expectations
  int c_done = 0, c_trunc = 0, c_gap = 0, c_par = 0;
  always @(negedge pll_clk) begin
    if (rst_n === 1'b1) begin
      c_done  <= c_done + int'(de_ser_done);
      c_trunc <= c_trunc + int'(trunc_err);
      c_gap   <= c_gap + int'(gap_err);
      c_par   <= c_par + int'(parity_err);
    end
  end

  int s_done, s_trunc, s_gap, s_par;
  task automatic snap();
    s_done = c_done; s_trunc = c_trunc; s_gap = c_gap; s_par = c_par;
  endtask

  task automatic chk_deltas(input string tag, input int d_done, input int d_trunc, input int d_gap);
    #1;
    chk({tag, "_done_cnt"}, W'(c_done - s_done), W'(d_done));
    chk({tag, "_trunc_cnt"}, W'(c_trunc - s_trunc), W'(d_trunc));
    chk({tag, "_gap_cnt"}, W'(c_gap - s_gap), W'(d_gap));
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pll_clk);
      RXCKSB = 1'b0; RXDATASB = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pll_clk);
      RXCKSB = 1'b1; RXDATASB = w[i];
    end
  endtask

  // first cycle after the last bit: result must be visible; this also starts the idle gap
  task automatic finish_pkt(input string tag, input logic [W-1:0] exp);
    @(negedge pll_clk);
    #1;
    chk({tag, "_done"}, W'(de_ser_done), W'(1));
    chk({tag, "_data"}, data_out, exp);
    RXCKSB = 1'b0; RXDATASB = 1'b0;
  endtask

  localparam logic [W-1:0] P1  = 64'hA5A5_0F0F_1234_5678;
  localparam logic [W-1:0] P2  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [W-1:0] P3  = 64'h1111_2222_3333_4444;
  localparam logic [W-1:0] P4  = 64'hFEDC_BA98_7654_3210;
  localparam logic [W-1:0] P5  = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [W-1:0] P6  = 64'h8000_0000_0000_0001;
  localparam logic [W-1:0] P7  = 64'hFFFF_0000_FFFF_0000;
  localparam logic [W-1:0] P8  = 64'hC3C3_3C3C_AAAA_5555;
  localparam logic [W-1:0] P9  = 64'h7777_8888_9999_AAAA;
  localparam logic [W-1:0] P10 = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [W-1:0] trunc_pat;
    logic [W-1:0] one_pkt;
    logic [W-1:0] three_pkt;
    logic         exp_par;
    trunc_pat = 64'h0000_0000_000F_FFFF;
    one_pkt   = 64'h1;
    three_pkt = 64'h3;
`ifdef SB_RX_PARITY_CHECK_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif

    rst_n = 1'b0; enable = 1'b0; RXCKSB = 1'b0; RXDATASB = 1'b0;
    repeat (3) @(negedge pll_clk);
    #1;
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_done", W'(de_ser_done), W'(0));
    chk("rst_trunc", W'(trunc_err), W'(0));
    chk("rst_gap", W'(gap_err), W'(0));
    chk("rst_parity", W'(parity_err), W'(0));
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    enable = 1'b1;

    // T1: basic packet
    idle(40);
    snap();
    send(P1, W);
    finish_pkt("t1", P1);
    idle(40);
    chk_deltas("t1", 1, 0, 0);

    // T2: truncated packet, then a full one
    snap();
    send(trunc_pat, 20);
    idle(40);
    chk_deltas("t2_trunc", 0, 1, 0);
    chk("t2_data_held", data_out, P1);
    snap();
    send(P2, W);
    finish_pkt("t2", P2);
    idle(40);
    chk_deltas("t2_next", 1, 0, 0);

    // T3: 10-cycle gap violates, exactly GAP_MIN does not
    snap();
    send(P3, W);
    finish_pkt("t3a", P3);
    idle(9);
    send(P4, W);
    finish_pkt("t3b", P4);
    idle(40);
    chk_deltas("t3_short", 2, 0, 1);
    snap();
    send(P5, W);
    finish_pkt("t3c", P5);
    idle(GAP_MIN - 1);
    send(P6, W);
    finish_pkt("t3d", P6);
    idle(40);
    chk_deltas("t3_exact", 2, 0, 0);

    // T4: disable mid-packet, re-enable, full packet
    snap();
    send(P7, 30);
    for (int i = 30; i < W; i++) begin
      @(negedge pll_clk);
      enable = 1'b0; RXCKSB = 1'b1; RXDATASB = P7[i];
    end
    idle(6);
    enable = 1'b1;
    idle(40);
    chk_deltas("t4_abort", 0, 0, 0);
    chk("t4_data_held", data_out, P6);
    snap();
    send(P8, W);
    finish_pkt("t4", P8);
    idle(40);
    chk_deltas("t4_next", 1, 0, 0);

    // T5: reset mid-packet
    send(P9, 50);
    @(negedge pll_clk);
    #2;
    rst_n = 1'b0;
    RXCKSB = 1'b0; RXDATASB = 1'b0;
    #1;
    chk("t5_rst_data", data_out, 64'h0);
    chk("t5_rst_done", W'(de_ser_done), W'(0));
    chk("t5_rst_trunc", W'(trunc_err), W'(0));
    chk("t5_rst_gap", W'(gap_err), W'(0));
    repeat (3) @(negedge pll_clk);
    rst_n = 1'b1;
    idle(2);
    snap();
    send(P10, W);
    finish_pkt("t5", P10);
    idle(40);
    chk_deltas("t5_next", 1, 0, 0);

    // T6: parity
    snap();
    send(one_pkt, W);
    @(negedge pll_clk);
    #1;
    chk("t6_odd_done", W'(de_ser_done), W'(1));
    chk("t6_odd_parity", W'(parity_err), W'(exp_par));
    RXCKSB = 1'b0; RXDATASB = 1'b0;
    idle(40);
    send(three_pkt, W);
    finish_pkt("t6_even", three_pkt);
    chk("t6_even_parity", W'(parity_err), W'(0));
    idle(5);
    #1;
    chk("t6_parity_cnt", W'(c_par - s_par), W'(exp_par));

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
